// File: rtl/pkt134_pkg.sv
// Shared constants, tag decoding and the transmit FSM encoding for the
// 134-bit packet stream to GMII egress path.
package pkt134_pkg;

  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;
  localparam logic [1:0] TAG_ONE  = 2'b11;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PRE_LEN       = 8;

  localparam int WORD_W = 134;
  // The read side never needs the head flag, so the buffer drops it.
  localparam int RAM_W  = 133;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_IFG  = 2'd3
  } tx_state_t;

  function automatic logic tag_is_head(input logic [1:0] tag);
    return (tag != TAG_BODY) && (tag != TAG_TAIL);
  endfunction

  function automatic logic tag_is_tail(input logic [1:0] tag);
    return (tag == TAG_TAIL) || (tag == TAG_ONE);
  endfunction

endpackage

// File: rtl/pkt134_tx_ram.sv
// Simple dual-port word buffer with a registered read port; maps onto block RAM.
module pkt134_tx_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 133
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/pkt134_gmii_tx.sv
// Store-and-forward egress: buffers whole packets, then emits preamble, SFD and
// packet bytes on GMII one byte per clock, followed by the inter-frame gap.
module pkt134_gmii_tx
  import pkt134_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int IFG_LEN = 12,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  input  logic [133:0]     pkt_data,
  output logic             buf_alm_full,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [CNT_W-1:0] tx_pkt_cnt,
  output logic [CNT_W-1:0] drop_pkt_cnt,
  output logic [1:0]       dbg_state
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [PW:0] ALM_THR = (PW+1)'(2 * DEPTH / 8);

  // Write-side state
  logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_pkt_start, r_rd_ptr;
  logic          r_in_pkt, r_dropping;
  logic [PW-1:0] w_wr_nxt, w_commit_nxt, w_start_nxt, w_base, w_used, w_used_wr;
  logic          w_in_pkt_nxt, w_dropping_nxt, w_ram_we, w_full;
  logic [1:0]    w_drop_add;
  logic [PW:0]   w_free;
  logic          w_is_head, w_is_tail;

  // Read-side state
  tx_state_t      r_state, w_state_nxt;
  logic [7:0]     r_cnt;
  logic [3:0]     r_byte;
  logic           r_rd_pend, r_nxt_vld;
  logic [RAM_W-1:0] r_nxt, w_ram_q;
  logic           r_cur_tail;
  logic [3:0]     r_cur_vld;
  logic [127:0]   r_cur_data, w_shift;
  logic           w_avail, w_frame_rdy, w_take, w_rd_issue, w_last;
  logic [7:0]     w_byte, w_txd_nxt;
  logic           w_en_nxt;

  assign w_is_head = tag_is_head(pkt_data[133:132]);
  assign w_is_tail = tag_is_tail(pkt_data[133:132]);

  // A new head over an unfinished packet reuses that packet's space.
  assign w_base = (w_is_head && r_in_pkt) ? r_pkt_start : r_wr_ptr;
  assign w_used = w_base - r_rd_ptr;
  assign w_full = w_used[ADDR_W];

  assign w_used_wr    = r_wr_ptr - r_rd_ptr;
  assign w_free       = (PW+1)'(DEPTH) - {1'b0, w_used_wr};
  assign buf_alm_full = (w_free < ALM_THR);

  always_comb begin : wr_ctrl
    w_wr_nxt       = r_wr_ptr;
    w_commit_nxt   = r_commit_ptr;
    w_start_nxt    = r_pkt_start;
    w_in_pkt_nxt   = r_in_pkt;
    w_dropping_nxt = r_dropping;
    w_drop_add     = 2'd0;
    w_ram_we       = 1'b0;
    if (pkt_valid) begin
      if (w_is_head) begin
        w_dropping_nxt = 1'b0;
        if (r_in_pkt) w_drop_add = 2'd1;
        if (w_full) begin
          w_wr_nxt       = w_base;
          w_in_pkt_nxt   = 1'b0;
          w_dropping_nxt = !w_is_tail;
          w_drop_add     = w_drop_add + 2'd1;
        end else begin
          w_ram_we     = 1'b1;
          w_wr_nxt     = w_base + PW'(1);
          w_start_nxt  = w_base;
          w_in_pkt_nxt = !w_is_tail;
          if (w_is_tail) w_commit_nxt = w_base + PW'(1);
        end
      end else if (r_in_pkt) begin
        if (w_full) begin
          w_wr_nxt       = r_pkt_start;
          w_in_pkt_nxt   = 1'b0;
          w_dropping_nxt = !w_is_tail;
          w_drop_add     = 2'd1;
        end else begin
          w_ram_we = 1'b1;
          w_wr_nxt = r_wr_ptr + PW'(1);
          if (w_is_tail) begin
            w_commit_nxt = r_wr_ptr + PW'(1);
            w_in_pkt_nxt = 1'b0;
          end
        end
      end else if (w_is_tail) begin
        w_dropping_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkt_start  <= '0;
      r_in_pkt     <= 1'b0;
      r_dropping   <= 1'b0;
      drop_pkt_cnt <= '0;
    end else begin
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_pkt_start  <= w_start_nxt;
      r_in_pkt     <= w_in_pkt_nxt;
      r_dropping   <= w_dropping_nxt;
      drop_pkt_cnt <= drop_pkt_cnt + CNT_W'(w_drop_add);
    end
  end

  pkt134_tx_ram #(.ADDR_W(ADDR_W), .DATA_W(RAM_W)) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_base[ADDR_W-1:0]),
    .i_wr_data ({pkt_data[133], pkt_data[131:0]}),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_ram_q)
  );

  // One-word prefetch slot; a read is only issued when the slot will be free
  // by the time the RAM data lands.
  assign w_avail     = (r_commit_ptr != r_rd_ptr);
  assign w_frame_rdy = w_avail || r_rd_pend || r_nxt_vld;
  assign w_last      = (r_byte == (r_cur_tail ? r_cur_vld : 4'hF));
  assign w_take      = ((r_state == ST_PRE) && (r_cnt == 8'(PRE_LEN-1))) ||
                       ((r_state == ST_DATA) && w_last && !r_cur_tail);
  assign w_rd_issue  = w_avail && !r_rd_pend && (!r_nxt_vld || w_take);
  assign w_shift     = r_cur_data << {r_byte, 3'b000};
  assign w_byte      = w_shift[127:120];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_rd_pend  <= 1'b0;
      r_nxt_vld  <= 1'b0;
      r_nxt      <= '0;
      r_cur_tail <= 1'b0;
      r_cur_vld  <= '0;
      r_cur_data <= '0;
    end else begin
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (r_rd_pend) begin
        r_nxt     <= w_ram_q;
        r_nxt_vld <= 1'b1;
      end else if (w_take) begin
        r_nxt_vld <= 1'b0;
      end
      if (w_take) begin
        r_cur_tail <= r_nxt[132];
        r_cur_vld  <= r_nxt[131:128];
        r_cur_data <= r_nxt[127:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // IFG hands straight to PRE so back-to-back frames see exactly IFG_LEN idles.
  always_comb begin : next_state
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_frame_rdy) w_state_nxt = ST_PRE;
      ST_PRE:  if (r_cnt == 8'(PRE_LEN-1)) w_state_nxt = ST_DATA;
      ST_DATA: if (w_last && r_cur_tail) w_state_nxt = ST_IFG;
      ST_IFG:  if (r_cnt == 8'(IFG_LEN-1)) w_state_nxt = w_frame_rdy ? ST_PRE : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : output_dec
    w_txd_nxt = 8'h00;
    w_en_nxt  = 1'b0;
    unique case (r_state)
      ST_PRE: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = (r_cnt == 8'(PRE_LEN-1)) ? SFD_BYTE : PREAMBLE_BYTE;
      end
      ST_DATA: begin
        w_en_nxt  = 1'b1;
        w_txd_nxt = w_byte;
      end
      default: begin
        w_en_nxt  = 1'b0;
        w_txd_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_byte     <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      tx_pkt_cnt <= '0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if ((r_state == ST_PRE) || (r_state == ST_IFG)) r_cnt <= r_cnt + 8'd1;
      if (r_state == ST_DATA) r_byte <= w_last ? 4'd0 : r_byte + 4'd1;
      else                    r_byte <= 4'd0;
      gmii_txd   <= w_txd_nxt;
      gmii_tx_en <= w_en_nxt;
      if ((r_state == ST_DATA) && w_last && r_cur_tail) tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
    end
  end

  assign gmii_tx_er = 1'b0;
  assign dbg_state  = r_state;

endmodule
